// File: rtl/lenet_hls_mac_acc_if.sv
// Handshake bundle for lenet_hls_mac_acc: product stream in, activation out.
// Ports: prod_din/prod_valid/prod_ready/bias_din, out_dout/out_sat/out_valid/out_ready.
`timescale 1ns/1ps
interface lenet_hls_mac_acc_if #(
   parameter int PROD_WIDTH = 50,
   parameter int BIAS_WIDTH = 32,
   parameter int OUT_WIDTH  = 16
);
   logic [PROD_WIDTH-1:0] prod_din;
   logic                  prod_valid;
   logic                  prod_ready;
   logic [BIAS_WIDTH-1:0] bias_din;
   logic [OUT_WIDTH-1:0]  out_dout;
   logic                  out_sat;
   logic                  out_valid;
   logic                  out_ready;

   // Producer / consumer side
   modport master (
      output prod_din, prod_valid, bias_din, out_ready,
      input  prod_ready, out_dout, out_sat, out_valid
   );

   // Accumulator side
   modport slave (
      input  prod_din, prod_valid, bias_din, out_ready,
      output prod_ready, out_dout, out_sat, out_valid
   );
endinterface

// File: rtl/lenet_hls_mac_acc.sv
// Bias + N_TERMS product accumulator with round-half-up rescale, ReLU, saturate.
// Ports: ap_clk, ap_rst (sync, active-high), bus (lenet_hls_mac_acc_if.slave).
`timescale 1ns/1ps
module lenet_hls_mac_acc #(
   parameter int PROD_WIDTH = 50,
   parameter int BIAS_WIDTH = 32,
   parameter int ACC_WIDTH  = 56,
   parameter int N_TERMS    = 25,
   parameter int SHIFT      = 24,
   parameter int OUT_WIDTH  = 16
) (
   input logic ap_clk,
   input logic ap_rst,
   lenet_hls_mac_acc_if.slave bus
);
   localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS - 1);
   localparam logic signed [ACC_WIDTH-1:0] RND_C =
      {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (SHIFT - 1);
   localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
      {{(ACC_WIDTH-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

   typedef enum logic [1:0] {ACCUM, ROUND, HOLD} state_t;

   state_t                       state_q, state_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
   logic [OUT_WIDTH-1:0]         dout_q, dout_d;
   logic                         sat_q, sat_d;
   logic                         valid_q, valid_d;

   logic                         accept;
   logic signed [ACC_WIDTH-1:0]  bias_ext;
   logic signed [ACC_WIDTH-1:0]  prod_ext;
   logic signed [ACC_WIDTH-1:0]  rnd_sum;
   logic signed [ACC_WIDTH-1:0]  r_val;

   assign bus.prod_ready = (state_q == ACCUM) && !ap_rst;
   assign accept = bus.prod_valid && bus.prod_ready;

   assign bus.out_dout  = dout_q;
   assign bus.out_sat   = sat_q;
   assign bus.out_valid = valid_q;

   assign bias_ext = {{(ACC_WIDTH-BIAS_WIDTH){bus.bias_din[BIAS_WIDTH-1]}},
                      bus.bias_din};
   assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){1'b0}}, bus.prod_din};

   // Round half up, then floor-divide by 2^SHIFT
   assign rnd_sum = acc_q + RND_C;
   assign r_val   = rnd_sum >>> SHIFT;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      dout_d  = dout_q;
      sat_d   = sat_q;
      valid_d = valid_q;
      unique case (state_q)
         ACCUM: begin
            if (accept) begin
               // First term of a window restarts from the bias
               if (cnt_q == '0) acc_d = bias_ext + prod_ext;
               else             acc_d = acc_q + prod_ext;
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = ROUND;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ROUND: begin
            if (r_val < 0) begin
               dout_d = '0;
               sat_d  = 1'b0;
            end else if (r_val > OUT_MAX) begin
               dout_d = '1;
               sat_d  = 1'b1;
            end else begin
               dout_d = r_val[OUT_WIDTH-1:0];
               sat_d  = 1'b0;
            end
            valid_d = 1'b1;
            state_d = HOLD;
         end
         HOLD: begin
            if (valid_q && bus.out_ready) begin
               valid_d = 1'b0;
               state_d = ACCUM;
            end
         end
         default: begin
            state_d = ACCUM;
         end
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q <= ACCUM;
         cnt_q   <= '0;
         acc_q   <= '0;
         dout_q  <= '0;
         sat_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         dout_q  <= dout_d;
         sat_q   <= sat_d;
         valid_q <= valid_d;
      end
   end
endmodule

// File: tb/tb_lenet_hls_mac_acc.sv
// Directed testbench for lenet_hls_mac_acc.
// Ports: none; drives the DUT through a lenet_hls_mac_acc_if instance.
`timescale 1ns/1ps
module tb_lenet_hls_mac_acc;
   localparam int PW = 50;
   localparam int BW = 32;
   localparam int AW = 56;
   localparam int NT = 25;
   localparam int SH = 24;
   localparam int OW = 16;

   localparam logic [PW-1:0] P24  = PW'(1) << 24;
   localparam logic [PW-1:0] P23  = PW'(1) << 23;
   localparam logic [PW-1:0] PMAX = (PW'(1) << 49) - PW'(1);

   logic ap_clk = 1'b0;
   logic ap_rst = 1'b1;
   int vectors = 0;
   int miscompares = 0;

   lenet_hls_mac_acc_if #(.PROD_WIDTH(PW), .BIAS_WIDTH(BW), .OUT_WIDTH(OW)) bus();

   lenet_hls_mac_acc #(
      .PROD_WIDTH(PW), .BIAS_WIDTH(BW), .ACC_WIDTH(AW),
      .N_TERMS(NT), .SHIFT(SH), .OUT_WIDTH(OW)
   ) dut (
      .ap_clk(ap_clk),
      .ap_rst(ap_rst),
      .bus(bus.slave)
   );

   always #5 ap_clk = ~ap_clk;

   // Present one product (after an optional idle gap) and return at the
   // negedge following the edge that accepted it.
   task automatic push(input logic [PW-1:0] p, input logic [BW-1:0] b, input int gap);
      int k;
      bus.prod_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
         bus.prod_din = PW'({$urandom, $urandom});
         @(negedge ap_clk);
      end
      bus.prod_din = p;
      bus.bias_din = b;
      bus.prod_valid = 1'b1;
      k = 0;
      while (bus.prod_ready !== 1'b1 && k < 60) begin
         @(negedge ap_clk);
         k++;
      end
      if (k >= 60) begin
         vectors++;
         miscompares++;
         $display("FAIL push_timeout prod_ready=%b required 1", bus.prod_ready);
      end
      @(negedge ap_clk);
      bus.prod_valid = 1'b0;
      bus.bias_din = $urandom;
   endtask

   // Full window: first term carries the bias, later terms get junk bias.
   task automatic window(input logic [BW-1:0] bias, input logic [PW-1:0] first,
                         input logic [PW-1:0] rest, input int maxgap);
      push(first, bias, int'($urandom_range(maxgap, 0)));
      for (int i = 1; i < NT; i++)
         push(rest, $urandom, int'($urandom_range(maxgap, 0)));
   endtask

   task automatic wait_valid(output logic [OW-1:0] d, output logic s);
      int k;
      k = 0;
      while (bus.out_valid !== 1'b1 && k < 60) begin
         @(negedge ap_clk);
         k++;
      end
      if (k >= 60) begin
         vectors++;
         miscompares++;
         $display("FAIL out_valid_timeout out_valid=%b required 1", bus.out_valid);
      end
      d = bus.out_dout;
      s = bus.out_sat;
   endtask

   task automatic test_reset();
      ap_rst = 1'b1;
      bus.prod_valid = 1'b1;
      bus.prod_din = P24;
      for (int i = 0; i < 3; i++) begin
         @(negedge ap_clk);
         vectors++;
         if (bus.prod_ready !== 1'b0 || bus.out_valid !== 1'b0 ||
             bus.out_dout !== 16'd0 || bus.out_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold rdy=%b vld=%b dout=%0d sat=%b required 0 0 0 0",
                     bus.prod_ready, bus.out_valid, bus.out_dout, bus.out_sat);
         end
      end
      ap_rst = 1'b0;
      bus.prod_valid = 1'b0;
      #1;
      vectors++;
      if (bus.prod_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_release prod_ready=%b required 1", bus.prod_ready);
      end
      @(negedge ap_clk);
   endtask

   task automatic test_basic_sum();
      bus.out_ready = 1'b1;
      window(32'd0, P24, P24, 0);
      vectors++;
      if (bus.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_latency_early out_valid=%b required 0", bus.out_valid);
      end
      @(negedge ap_clk);
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_dout !== 16'd25 || bus.out_sat !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_sum vld=%b dout=%0d sat=%b required 1 25 0",
                  bus.out_valid, bus.out_dout, bus.out_sat);
      end
      @(negedge ap_clk);
      vectors++;
      if (bus.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_valid_width out_valid=%b required 0", bus.out_valid);
      end
   endtask

   task automatic test_rounding();
      logic [OW-1:0] d;
      logic s;
      bus.out_ready = 1'b1;
      window(32'd0, P23, '0, 0);
      wait_valid(d, s);
      vectors++;
      if (d !== 16'd1 || s !== 1'b0) begin
         miscompares++;
         $display("FAIL round_half_up dout=%0d sat=%b required 1 0", d, s);
      end
      @(negedge ap_clk);
      window(32'd0, P23 - PW'(1), '0, 0);
      wait_valid(d, s);
      vectors++;
      if (d !== 16'd0 || s !== 1'b0) begin
         miscompares++;
         $display("FAIL round_below_half dout=%0d sat=%b required 0 0", d, s);
      end
      @(negedge ap_clk);
   endtask

   task automatic test_relu();
      logic [OW-1:0] d;
      logic s;
      bus.out_ready = 1'b1;
      window(32'hC000_0000, P24, P24, 0);
      wait_valid(d, s);
      vectors++;
      if (d !== 16'd0 || s !== 1'b0) begin
         miscompares++;
         $display("FAIL relu dout=%0d sat=%b required 0 0", d, s);
      end
      @(negedge ap_clk);
   endtask

   task automatic test_saturate_backpressure();
      logic [OW-1:0] d;
      logic s;
      bus.out_ready = 1'b0;
      window(32'd0, PMAX, PMAX, 0);
      wait_valid(d, s);
      vectors++;
      if (d !== 16'hFFFF || s !== 1'b1) begin
         miscompares++;
         $display("FAIL saturate dout=%0d sat=%b required 65535 1", d, s);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge ap_clk);
         vectors++;
         if (bus.out_valid !== 1'b1 || bus.out_dout !== 16'hFFFF ||
             bus.out_sat !== 1'b1 || bus.prod_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_stable cyc=%0d vld=%b dout=%0d sat=%b rdy=%b required 1 65535 1 0",
                     i, bus.out_valid, bus.out_dout, bus.out_sat, bus.prod_ready);
         end
      end
      bus.out_ready = 1'b1;
      @(negedge ap_clk);
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.prod_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL hold_release vld=%b rdy=%b required 0 1",
                  bus.out_valid, bus.prod_ready);
      end
      window(32'd0, PMAX, PMAX, 3);
      wait_valid(d, s);
      vectors++;
      if (d !== 16'hFFFF || s !== 1'b1) begin
         miscompares++;
         $display("FAIL saturate_gaps dout=%0d sat=%b required 65535 1", d, s);
      end
      @(negedge ap_clk);
   endtask

   task automatic test_reset_mid_window();
      logic [OW-1:0] d;
      logic s;
      bus.out_ready = 1'b1;
      push(PW'(1) << 45, 32'h4000_0000, 0);
      for (int i = 1; i < 12; i++) push(PW'(1) << 45, $urandom, 0);
      ap_rst = 1'b1;
      @(negedge ap_clk);
      vectors++;
      if (bus.prod_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset rdy=%b vld=%b required 0 0", bus.prod_ready, bus.out_valid);
      end
      ap_rst = 1'b0;
      window(32'h0100_0000, P24, P24, 1);
      wait_valid(d, s);
      vectors++;
      if (d !== 16'd26 || s !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset_result dout=%0d sat=%b required 26 0", d, s);
      end
      @(negedge ap_clk);
   endtask

   initial begin
      bus.prod_din = '0;
      bus.prod_valid = 1'b0;
      bus.bias_din = '0;
      bus.out_ready = 1'b1;
      test_reset();
      test_basic_sum();
      test_rounding();
      test_relu();
      test_saturate_backpressure();
      test_reset_mid_window();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/lenet_hls_mac_acc.md
# lenet_hls_mac_acc

Downstream consumer of the 25×25→50 unsigned product stage in the LeNet convolution/dense datapath. Accepts a stream of N_TERMS products over a valid/ready handshake and accumulates them onto a signed bias. It then rescales with round-half-up, applies ReLU and saturates, and presents one activation per window on a registered valid/ready output. One instance serves one output neuron/pixel at a time.

## Interface
- PROD_WIDTH, 50, width of the unsigned product input.
- BIAS_WIDTH, 32, width of the signed bias, already in product scale.
- ACC_WIDTH, 56, signed accumulator width. Must be ≥ PROD_WIDTH + clog2(N_TERMS) + 1.
- N_TERMS, 25, products per output (5×5 kernel), ≥ 1.
- SHIFT, 24, right shift applied after accumulation, ≥ 1.
- OUT_WIDTH, 16, unsigned activation width.
- ap_clk  in  1  clock; all state updates on the rising edge.
- ap_rst  in  1  reset, synchronous, active-high.
- prod_din  in  PROD_WIDTH  unsigned product.
- prod_valid  in  1  product present.
- prod_ready  out  1  block can accept a product.
- bias_din  in  BIAS_WIDTH  signed bias, sampled with the first term of each window.
- out_dout  out  OUT_WIDTH  activation result.
- out_sat  out  1  set when the result was clipped to the maximum.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.

## Operation
- **States:** ACCUM, ROUND, HOLD. Reset state is ACCUM.
- **Accept rule:** a product is accepted when prod_valid && prod_ready.
- **prod_ready:** high only in ACCUM with ap_rst low.
- **Term counter:** cnt counts 0..N_TERMS-1.
- **ACCUM:**
  - On accept with cnt==0: acc ← sign_ext(bias_din) + zero_ext(prod_din).
  - On accept with cnt>0: acc ← acc + zero_ext(prod_din).
  - On accept with cnt==N_TERMS-1: cnt ← 0 and go to ROUND. Otherwise cnt++.
  - No accept: hold all state.
- **ROUND** (single cycle, no input accepted):
  - r = (acc + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift).
  - If r < 0: out_dout ← 0, out_sat ← 0.
  - Else if r > 2^OUT_WIDTH-1: out_dout ← all ones, out_sat ← 1.
  - Else: out_dout ← r[OUT_WIDTH-1:0], out_sat ← 0.
  - Then out_valid ← 1 and go to HOLD.
- **HOLD:**
  - out_dout, out_sat and out_valid are held stable while out_ready is low.
  - On out_valid && out_ready: out_valid ← 0 and go to ACCUM.
- **Overflow:** with the parameter constraint satisfied, acc never wraps. No wrap handling is required.
- **Reset mid-operation:** ap_rst high in any state aborts the window. Partial acc and cnt are discarded and the next accepted product starts a new window with a fresh bias sample.
- **Reset values:** prod_ready 0 while ap_rst is high, 1 on the first cycle after. out_dout 0, out_sat 0, out_valid 0, cnt 0, acc 0, state ACCUM.

## Timing
- **Latency:** last product accepted at edge t → ROUND in cycle t..t+1 → out_valid high from edge t+1. Result visible one cycle after the last accept, two edges from the last prod_valid cycle.
- **Throughput:** at most one product per cycle. Minimum window period is N_TERMS + 2 cycles (ROUND + one HOLD cycle with out_ready high).
- **Handshakes:** prod_valid may toggle freely and gaps are allowed. cnt advances only on accept. All outputs are registered; no combinational path from out_ready to out_dout.
- **Bias timing:** bias_din is ignored except on the cycle the cnt==0 term is accepted.

## Test plan
1. **Reset:** hold ap_rst 3 cycles with prod_valid=1 → prod_ready=0, out_valid=0, out_dout=0, out_sat=0 throughout. prod_ready=1 the cycle after release.
2. **Basic sum:** bias=0, 25 products each 2^24, back-to-back, out_ready=1 → out_dout=25, out_sat=0. out_valid rises one cycle after the 25th accept and stays high exactly 1 cycle.
3. **Rounding boundary:** bias=0, one product 2^23, 24 zeros → out_dout=1. Repeat with 2^23−1 → out_dout=0.
4. **ReLU:** bias=−2^30, 25 products of 2^24 → r=−39 → out_dout=0, out_sat=0.
5. **Saturation and backpressure:** 25 products of 2^49−1 with out_ready=0 for 10 cycles → out_dout=65535, out_sat=1, held stable; prod_ready=0 during HOLD. Random prod_valid gaps give the same result.
6. **Reset mid-window:** assert ap_rst after 12 accepted terms, then send bias=2^24 and 25 products of 2^24 → out_dout=26. No contribution from the aborted terms.
